// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
// ST_MUL exists only when ALU_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_INC  = 4'h6,
    OP_SHR1 = 4'h7,
    OP_ADC  = 4'h8,
    OP_SBB  = 4'h9,
    OP_DEC  = 4'hA,
    OP_SHL  = 4'hB,
    OP_SHRV = 4'hC,
    OP_SRA  = 4'hD,
    OP_CMP  = 4'hE,
    OP_MUL  = 4'hF
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef ALU_MUL_EN
    , ST_MUL = 2'd2
`endif
  } state_e;

  function automatic logic [3:0] mk_flags(input logic n, input logic z, input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle datapath for opcodes 0-A and E: result plus NZCV.
// Pure combinational; the top registers the outputs.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  input  logic             cflag_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] add_b, sub_b, res, nz_src;
  logic             add_c, sub_c, c, v, v_add, v_sub;
  logic [WIDTH:0]   sum, diff;

  assign add_b = (op_i == OP_INC) ? ONE : b_i;
  assign sub_b = (op_i == OP_DEC) ? ONE : b_i;
  assign add_c = (op_i == OP_ADC) && cflag_i;
  assign sub_c = (op_i == OP_SBB) && cflag_i;

  // The extra top bit of diff is the borrow: it wraps to 1 exactly when A < B + borrow-in.
  assign sum   = {1'b0, a_i} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
  assign diff  = {1'b0, a_i} - {1'b0, sub_b} - {{WIDTH{1'b0}}, sub_c};
  assign v_add = (a_i[M] == add_b[M]) && (sum[M] != a_i[M]);
  assign v_sub = (a_i[M] != sub_b[M]) && (diff[M] != a_i[M]);

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_i)
      OP_ADD, OP_ADC, OP_INC: begin res = sum[M:0];  c = sum[WIDTH];  v = v_add; end
      OP_SUB, OP_SBB, OP_DEC: begin res = diff[M:0]; c = diff[WIDTH]; v = v_sub; end
      OP_CMP:                 begin res = a_i;       c = diff[WIDTH]; v = v_sub; end
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NOT:  res = ~a_i;
      OP_SHR1: begin res = {1'b0, a_i[M:1]}; c = a_i[0]; end
      default: res = '0;
    endcase
  end

  assign nz_src   = (op_i == OP_CMP) ? diff[M:0] : res;
  assign result_o = res;
  assign flags_o  = mk_flags(nz_src[M], nz_src == '0, c, v);

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready on both sides; 1-cycle ops, bit-serial shifts (n+1 edges),
// and with ALU_MUL_EN a shift-add multiply (WIDTH+1 edges). Input stalls while busy or output is held.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam int M  = WIDTH - 1;
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e           state_q;
  logic             out_valid_q, out_err_q, cflag_q;
  logic [WIDTH-1:0] out_result_q, sh_val_q, sh_nxt_d, comb_res;
  logic [3:0]       out_flags_q, comb_flags;
  logic [CW-1:0]    cnt_q;
  op_e              sh_op_q, op;
  logic [SHW-1:0]   shamt;
  logic             accept, is_vshift, sh_bit_d;
`ifdef ALU_MUL_EN
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
  logic [2*WIDTH-1:0] mul_acc_q, mul_a_q, mul_acc_d;
  logic [WIDTH-1:0]   mul_b_q;
`endif

  assign op        = op_e'(in_op);
  assign shamt     = in_b[SHW-1:0];
  assign is_vshift = (op == OP_SHL) || (op == OP_SHRV) || (op == OP_SRA);
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (op),
    .cflag_i  (cflag_q),
    .result_o (comb_res),
    .flags_o  (comb_flags)
  );

  always_comb begin
    sh_nxt_d = {1'b0, sh_val_q[M:1]};
    sh_bit_d = sh_val_q[0];
    if (sh_op_q == OP_SHL) begin
      sh_nxt_d = {sh_val_q[M-1:0], 1'b0};
      sh_bit_d = sh_val_q[M];
    end else if (sh_op_q == OP_SRA) begin
      sh_nxt_d = {sh_val_q[M], sh_val_q[M:1]};
    end
  end

`ifdef ALU_MUL_EN
  assign mul_acc_d = mul_b_q[0] ? (mul_acc_q + mul_a_q) : mul_acc_q;
`endif

  // The final shift/multiply step is folded into the load edge, so nothing loads an extra cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_err_q    <= 1'b0;
      cflag_q      <= 1'b0;
      sh_val_q     <= '0;
      sh_op_q      <= OP_ADD;
      cnt_q        <= '0;
`ifdef ALU_MUL_EN
      mul_acc_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
`endif
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_vshift && shamt != '0) begin
              state_q  <= ST_SHIFT;
              sh_val_q <= in_a;
              sh_op_q  <= op;
              cnt_q    <= {1'b0, shamt};
`ifdef ALU_MUL_EN
            end else if (op == OP_MUL) begin
              state_q   <= ST_MUL;
              mul_acc_q <= '0;
              mul_a_q   <= {{WIDTH{1'b0}}, in_a};
              mul_b_q   <= in_b;
              cnt_q     <= CNT_MUL;
`else
            end else if (op == OP_MUL) begin
              out_valid_q  <= 1'b1;
              out_result_q <= '0;
              out_flags_q  <= mk_flags(1'b0, 1'b1, 1'b0, 1'b0);
              out_err_q    <= 1'b1;
              cflag_q      <= 1'b0;
`endif
            end else if (is_vshift) begin
              out_valid_q  <= 1'b1;
              out_result_q <= in_a;
              out_flags_q  <= mk_flags(in_a[M], in_a == '0, 1'b0, 1'b0);
              out_err_q    <= 1'b0;
              cflag_q      <= 1'b0;
            end else begin
              out_valid_q  <= 1'b1;
              out_result_q <= comb_res;
              out_flags_q  <= comb_flags;
              out_err_q    <= 1'b0;
              cflag_q      <= comb_flags[FLAG_C];
            end
          end
        end
        ST_SHIFT: begin
          cnt_q    <= cnt_q - CNT_ONE;
          sh_val_q <= sh_nxt_d;
          if (cnt_q == CNT_ONE) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b1;
            out_result_q <= sh_nxt_d;
            out_flags_q  <= mk_flags(sh_nxt_d[M], sh_nxt_d == '0, sh_bit_d, 1'b0);
            out_err_q    <= 1'b0;
            cflag_q      <= sh_bit_d;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          cnt_q     <= cnt_q - CNT_ONE;
          mul_acc_q <= mul_acc_d;
          mul_a_q   <= mul_a_q << 1;
          mul_b_q   <= mul_b_q >> 1;
          if (cnt_q == CNT_ONE) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b1;
            out_result_q <= mul_acc_d[M:0];
            out_flags_q  <= mk_flags(mul_acc_d[M], mul_acc_d[M:0] == '0,
                                     mul_acc_d[2*WIDTH-1:WIDTH] != '0, 1'b0);
            out_err_q    <= 1'b0;
            cflag_q      <= mul_acc_d[2*WIDTH-1:WIDTH] != '0;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboarded bench for alu_seq_core at WIDTH=8; expectations come from an integer reference model.
module tb_alu_seq_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_err;
  logic [W-1:0] in_a, in_b, out_result;
  logic [3:0]   in_op, out_flags;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
    int         lat;
    int         ld;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   w;
  logic m_cf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model in plain integer arithmetic; tracks the carry flag in program order.
  task automatic predict(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output exp_t e);
    int ua, ub, sa, sbv, full, sres, n, cin;
    logic [7:0] r, nz;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    n = int'(b[2:0]);
    c = 1'b0; v = 1'b0; r = 8'h00; full = 0;
    e.op = op; e.err = 1'b0; e.lat = 1; e.ld = -1;
    case (op)
      4'h0, 4'h6, 4'h8: begin
        if (op == 4'h6) begin ub = 1; sbv = 1; end
        cin  = (op == 4'h8) ? int'(m_cf) : 0;
        full = ua + ub + cin;
        sres = sa + sbv + cin;
        r = full[7:0]; c = full > 255; v = (sres > 127) || (sres < -128);
      end
      4'h1, 4'h9, 4'hA, 4'hE: begin
        if (op == 4'hA) begin ub = 1; sbv = 1; end
        cin  = (op == 4'h9) ? int'(m_cf) : 0;
        full = ua - ub - cin;
        sres = sa - sbv - cin;
        r = (op == 4'hE) ? a : full[7:0];
        c = full < 0; v = (sres > 127) || (sres < -128);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h7: begin r = a >> 1; c = a[0]; end
      4'hB: begin r = a << n; c = (n != 0) ? a[8-n] : 1'b0; e.lat = n + 1; end
      4'hC: begin r = a >> n; c = (n != 0) ? a[n-1] : 1'b0; e.lat = n + 1; end
      4'hD: begin r = 8'($signed(a) >>> n); c = (n != 0) ? a[n-1] : 1'b0; e.lat = n + 1; end
      default: begin
`ifdef ALU_MUL_EN
        full = ua * ub; r = full[7:0]; c = full > 255; e.lat = W + 1;
`else
        r = 8'h00; e.err = 1'b1;
`endif
      end
    endcase
    nz = (op == 4'hE) ? full[7:0] : r;
    e.res   = r;
    e.flags = {nz[7], nz == 8'h00, c, v};
    m_cf    = c;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit latchk, output int waited);
    exp_t e;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      check("accept timeout", 32'(waited), 0);
      in_valid = 1'b0;
      return;
    end
    predict(op, a, b, e);
    e.ld = latchk ? (cyc + e.lat) : -1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      check("drain timeout", 32'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected output", 32'(out_result), 32'hDEAD);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result op%0h", mon_e.op), 32'(out_result), 32'(mon_e.res));
        check($sformatf("flags op%0h", mon_e.op), 32'(out_flags), 32'(mon_e.flags));
        check($sformatf("err op%0h", mon_e.op), 32'(out_err), 32'(mon_e.err));
        if (mon_e.ld >= 0) check($sformatf("latency op%0h", mon_e.op), 32'(cyc), 32'(mon_e.ld));
      end
    end
  end

  logic [19:0] tbl [12] = '{
    {4'h2, 8'hF0, 8'h3C}, {4'h3, 8'hF0, 8'h0F}, {4'h4, 8'hAA, 8'h55}, {4'h5, 8'hFF, 8'h00},
    {4'h7, 8'h81, 8'h00}, {4'h6, 8'h7F, 8'h00}, {4'hA, 8'h00, 8'h00}, {4'hE, 8'h10, 8'h20},
    {4'h9, 8'h50, 8'h10}, {4'hB, 8'h81, 8'h08}, {4'h1, 8'h05, 8'h09}, {4'hC, 8'h80, 8'h07}
  };

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1; m_cf = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_result", 32'(out_result), 0);
    check("reset out_flags", 32'(out_flags), 0);
    check("reset out_err", 32'(out_err), 0);
    @(negedge clk); rst = 1'b0;
    #2 check("in_ready after reset", 32'(in_ready), 1);
    @(negedge clk);

    issue(4'h0, 8'hD7, 8'h41, 1, w);
    drain();

    // Reset in the middle of a 7-bit shift; the previous result must also clear.
    issue(4'hC, 8'hCF, 8'h07, 1, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midshift rst out_valid", 32'(out_valid), 0);
    check("midshift rst out_result", 32'(out_result), 0);
    check("midshift rst out_flags", 32'(out_flags), 0);
    check("midshift rst out_err", 32'(out_err), 0);
    sb.delete();
    m_cf = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #2 check("in_ready after midshift rst", 32'(in_ready), 1);
    @(negedge clk);
    issue(4'h8, 8'h10, 8'h20, 1, w);
    drain();

    issue(4'h0, 8'hFF, 8'h01, 1, w);
    issue(4'h8, 8'h10, 8'h20, 1, w);
    issue(4'h1, 8'h80, 8'h01, 1, w);
    drain();

    issue(4'hC, 8'hCF, 8'h03, 1, w);
    for (int i = 0; i < 3; i++) begin
      #2 check($sformatf("in_ready busy shift %0d", i), 32'(in_ready), 0);
      @(negedge clk);
    end
    drain();
    issue(4'hD, 8'hCF, 8'h03, 1, w);
    issue(4'hB, 8'hCF, 8'h03, 1, w);
    drain();

    for (int i = 0; i < 12; i++) issue(tbl[i][19:16], tbl[i][15:8], tbl[i][7:0], 1, w);
    drain();

    // Held output must stay put and block input; release and new input land on the same edge.
    out_ready = 1'b0;
    issue(4'h0, 8'h05, 8'h03, 0, w);
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("bp out_valid %0d", i), 32'(out_valid), 1);
      check($sformatf("bp out_result %0d", i), 32'(out_result), 32'h08);
      check($sformatf("bp in_ready %0d", i), 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(4'h4, 8'hF0, 8'hFF, 1, w);
    check("bp accept same cycle", 32'(w), 0);
    drain();

    issue(4'hF, 8'h0D, 8'h05, 1, w);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [3:0] rop;
      logic [7:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      issue(rop, ra, rb, 1, w);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
